judge_rr: RTL and testbench

//  Parametrised successor of the router conflict judge. Takes NIN input ports,

---
 rtl/judge_rr.sv | 229 ++++++++++++++++++++++
 tb/tb_judge_rr.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/judge_rr.sv
// ============================================================================
// judge_rr -- parametrised output-contention judge for a router crossbar.
//
// Each of NIN input ports presents a DW-bit destination code (0 = NONE).
// Every output code d in 1..2**DW-1 has its own round-robin pointer; the
// winner of d is picked by, in priority order:
//   (1) the current lock owner of d (lock build only),
//   (2) the lowest-index starved candidate (fail counter saturated),
//   (3) the first candidate at or after ptr[d], scanning upward mod NIN.
// grant/fail/starve are registered and stay put while enable is low.
//
// Optional feature macro: JUDGE_RR_LOCK_EN
//   When defined, a grant with last=0 locks the output to that input until
//   the owner is granted with last=1 or the owner stops requesting that
//   output. When undefined, last is ignored and no lock state exists.
//
// Ports:
//   clk     in   1       clock, rising edge
//   rst_n   in   1       synchronous active-low reset
//   enable  in   1       arbitration step enable (0 = hold everything)
//   dst     in   NIN*DW  dst[i*DW +: DW] = destination of input i (0 = NONE)
//   last    in   NIN     tail-flit flag per input (lock build only)
//   grant   out  NIN     input i won its destination
//   fail    out  NIN     input i requested and lost
//   starve  out  NIN     fail counter of input i is at STARVE_MAX
// ============================================================================
module judge_rr #(
    parameter int NIN        = 3,
    parameter int DW         = 2,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [NIN*DW-1:0] dst,
    input  logic [NIN-1:0]    last,
    output logic [NIN-1:0]    grant,
    output logic [NIN-1:0]    fail,
    output logic [NIN-1:0]    starve
);

    // Destination codes index arrays directly; entry 0 (NONE) is never used.
    localparam int              NDST    = 1 << DW;
    localparam int              PW      = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int              CW      = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STARVE_MAX);

    // ------------------------------------------------------------------
    // Input unpacking
    // ------------------------------------------------------------------
    logic [DW-1:0]  dst_arr [NIN];
    logic [NIN-1:0] req;
    logic [NIN-1:0] starved;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]  ptr_q   [NDST];
    logic [PW-1:0]  ptr_d   [NDST];
    logic [CW-1:0]  cnt_q   [NIN];
    logic [CW-1:0]  cnt_d   [NIN];
    logic [NIN-1:0] grant_q;
    logic [NIN-1:0] grant_d;
    logic [NIN-1:0] fail_q;
    logic [NIN-1:0] fail_d;
    logic [NIN-1:0] starve_q;
    logic [NIN-1:0] starve_d;

`ifdef JUDGE_RR_LOCK_EN
    logic [NDST-1:0] lock_vld_q;
    logic [NDST-1:0] lock_vld_d;
    logic [PW-1:0]   lock_own_q [NDST];
    logic [PW-1:0]   lock_own_d [NDST];
`else
    // Tail flags only matter for locking.
    logic unused_last;
    assign unused_last = ^last;
`endif

    generate
        for (genvar gi = 0; gi < NIN; gi++) begin : g_in
            assign dst_arr[gi] = dst[gi*DW +: DW];
            assign req[gi]     = |dst_arr[gi];
            // Starvation priority is judged on the counter value entering
            // this cycle, not the one being computed.
            assign starved[gi] = (cnt_q[gi] == CNT_MAX);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-output arbitration
    // ------------------------------------------------------------------
    always_comb begin
        logic [NIN-1:0] cand;
        logic           found;
        logic           via_lock;
        int             win;
        int             idx;

        grant_d = '0;
        for (int d = 0; d < NDST; d++) begin
            ptr_d[d] = ptr_q[d];
`ifdef JUDGE_RR_LOCK_EN
            // A lock survives only by being re-established below.
            lock_vld_d[d] = 1'b0;
            lock_own_d[d] = lock_own_q[d];
`endif
            cand     = '0;
            found    = 1'b0;
            via_lock = 1'b0;
            win      = 0;

            if (d != 0) begin
                for (int i = 0; i < NIN; i++) begin
                    cand[i] = (dst_arr[i] == DW'(d));
                end
            end

`ifdef JUDGE_RR_LOCK_EN
            // Owner still targeting d keeps it, even against starved inputs.
            // If the owner moved away, d falls through to normal arbitration.
            if (lock_vld_q[d] && cand[lock_own_q[d]]) begin
                found    = 1'b1;
                via_lock = 1'b1;
                win      = int'(lock_own_q[d]);
            end
`endif

            // Starvation override: lowest index wins.
            for (int i = 0; i < NIN; i++) begin
                if (!found && cand[i] && starved[i]) begin
                    found = 1'b1;
                    win   = i;
                end
            end

            // Round-robin scan from the pointer, wrapping at NIN.
            for (int k = 0; k < NIN; k++) begin
                idx = int'(ptr_q[d]) + k;
                if (idx >= NIN) begin
                    idx = idx - NIN;
                end
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end

            if (found) begin
                grant_d[win] = 1'b1;
`ifdef JUDGE_RR_LOCK_EN
                if (!last[win]) begin
                    lock_vld_d[d] = 1'b1;
                    lock_own_d[d] = PW'(win);
                end
                // A held lock freezes the pointer; the releasing tail grant
                // advances it like a normal grant.
                if (!via_lock || last[win]) begin
                    ptr_d[d] = PW'((win + 1) % NIN);
                end
`else
                ptr_d[d] = PW'((win + 1) % NIN);
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // Fail / starvation counters
    // ------------------------------------------------------------------
    always_comb begin
        fail_d   = req & ~grant_d;
        starve_d = '0;
        for (int i = 0; i < NIN; i++) begin
            if (!req[i] || grant_d[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
            starve_d[i] = (cnt_d[i] == CNT_MAX);
        end
    end

    // ------------------------------------------------------------------
    // Registers: reset wins over enable; enable low holds all state.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q  <= '0;
            fail_q   <= '0;
            starve_q <= '0;
            for (int d = 0; d < NDST; d++) begin
                ptr_q[d] <= '0;
            end
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= '0;
            end
`ifdef JUDGE_RR_LOCK_EN
            lock_vld_q <= '0;
            for (int d = 0; d < NDST; d++) begin
                lock_own_q[d] <= '0;
            end
`endif
        end else if (enable) begin
            grant_q  <= grant_d;
            fail_q   <= fail_d;
            starve_q <= starve_d;
            for (int d = 0; d < NDST; d++) begin
                ptr_q[d] <= ptr_d[d];
            end
            for (int i = 0; i < NIN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`ifdef JUDGE_RR_LOCK_EN
            lock_vld_q <= lock_vld_d;
            for (int d = 0; d < NDST; d++) begin
                lock_own_q[d] <= lock_own_d[d];
            end
`endif
        end
    end

    assign grant  = grant_q;
    assign fail   = fail_q;
    assign starve = starve_q;

endmodule

// File: tb/tb_judge_rr.sv
// ============================================================================
// tb_judge_rr -- self-checking bench for judge_rr (NIN=3, DW=2, STARVE_MAX=2).
// Directed scenarios plus a randomized run against a queue-based reference
// model of the arbitration rules. Lock scenarios are compiled in only when
// JUDGE_RR_LOCK_EN is defined.
// ============================================================================
module tb_judge_rr;

    localparam int NIN  = 3;
    localparam int DW   = 2;
    localparam int SM   = 2;
    localparam int NDST = 1 << DW;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [NIN*DW-1:0] dst;
    logic [NIN-1:0]    last;
    logic [NIN-1:0]    grant;
    logic [NIN-1:0]    fail;
    logic [NIN-1:0]    starve;

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus values (one destination code / tail flag per input)
    int m_dst  [NIN];
    bit m_last [NIN];

    // Reference model state
    int           m_ptr  [NDST];
    int           m_cnt  [NIN];
    int           m_lock [NDST];   // -1 = free
    logic [NIN-1:0] m_grant, m_fail, m_starve;

    judge_rr #(.NIN(NIN), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .dst    (dst),
        .last   (last),
        .grant  (grant),
        .fail   (fail),
        .starve (starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int d = 0; d < NDST; d++) begin
            m_ptr[d]  = 0;
            m_lock[d] = -1;
        end
        for (int i = 0; i < NIN; i++) m_cnt[i] = 0;
        m_grant  = '0;
        m_fail   = '0;
        m_starve = '0;
    endtask

    // One arbitration step straight from the rules: lock owner, then the
    // lowest starved requester, then the first requester at/after the pointer.
    task automatic model_step();
        int cands[$];
        int w;
        bit via_lock;
        logic [NIN-1:0] g;
        g = '0;
        for (int d = 1; d < NDST; d++) begin
            cands.delete();
            for (int i = 0; i < NIN; i++) if (m_dst[i] == d) cands.push_back(i);
            w = -1;
            via_lock = 0;
`ifdef JUDGE_RR_LOCK_EN
            if (m_lock[d] >= 0 && m_dst[m_lock[d]] == d) begin
                w = m_lock[d];
                via_lock = 1;
            end
`endif
            if (w < 0) begin
                foreach (cands[j]) if (w < 0 && m_cnt[cands[j]] == SM) w = cands[j];
            end
            if (w < 0) begin
                for (int k = 0; k < NIN; k++) begin
                    int c;
                    c = (m_ptr[d] + k) % NIN;
                    if (w < 0 && m_dst[c] == d) w = c;
                end
            end
            m_lock[d] = -1;
            if (w >= 0) begin
                g[w] = 1'b1;
`ifdef JUDGE_RR_LOCK_EN
                if (!m_last[w]) m_lock[d] = w;
                if (!via_lock || m_last[w]) m_ptr[d] = (w + 1) % NIN;
`else
                m_ptr[d] = (w + 1) % NIN;
`endif
            end
        end
        for (int i = 0; i < NIN; i++) begin
            m_grant[i] = g[i];
            m_fail[i]  = (m_dst[i] != 0) && !g[i];
            if (m_dst[i] == 0 || g[i]) m_cnt[i] = 0;
            else if (m_cnt[i] < SM) m_cnt[i] = m_cnt[i] + 1;
            m_starve[i] = (m_cnt[i] == SM);
        end
    endtask

    // Drive the current stimulus, advance the model, and move one edge on.
    task automatic step();
        for (int i = 0; i < NIN; i++) begin
            dst[i*DW +: DW] = DW'(m_dst[i]);
            last[i]         = m_last[i];
        end
        if (!rst_n) model_reset();
        else if (enable) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input int d, input bit l);
        for (int i = 0; i < NIN; i++) begin
            m_dst[i]  = d;
            m_last[i] = l;
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < NIN; i++) begin
            m_dst[i]  = $urandom_range(0, NDST - 1);
            m_last[i] = 1'b1;
        end
        step();
        rst_n = 1'b1;
        n_cmp++;
        if (grant !== 3'b000) begin n_bad++; $display("FAIL reset_grant got=%b want=000", grant); end
        n_cmp++;
        if (fail !== 3'b000) begin n_bad++; $display("FAIL reset_fail got=%b want=000", fail); end
        n_cmp++;
        if (starve !== 3'b000) begin n_bad++; $display("FAIL reset_starve got=%b want=000", starve); end
        $display("txn reset grant=%b fail=%b starve=%b", grant, fail, starve);
    endtask

    task automatic test_rotation();
        logic [NIN-1:0] exp_g [3];
        logic [NIN-1:0] exp_f [3];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
        exp_f[0] = 3'b110; exp_f[1] = 3'b101; exp_f[2] = 3'b011;
        test_reset();
        set_all(1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            $display("txn rotation c=%0d grant=%b fail=%b starve=%b", c, grant, fail, starve);
            n_cmp++;
            if (grant !== exp_g[c]) begin n_bad++; $display("FAIL rotation_grant c=%0d got=%b want=%b", c, grant, exp_g[c]); end
            n_cmp++;
            if (fail !== exp_f[c]) begin n_bad++; $display("FAIL rotation_fail c=%0d got=%b want=%b", c, fail, exp_f[c]); end
            n_cmp++;
            if (starve !== m_starve) begin n_bad++; $display("FAIL rotation_starve c=%0d got=%b want=%b", c, starve, m_starve); end
        end
    endtask

    task automatic test_parallel();
        set_all(0, 1'b1);
        m_dst[0] = 1; m_dst[1] = 2; m_dst[2] = 3;
        step();
        $display("txn parallel grant=%b fail=%b", grant, fail);
        n_cmp++;
        if (grant !== 3'b111) begin n_bad++; $display("FAIL parallel_grant got=%b want=111", grant); end
        n_cmp++;
        if (fail !== 3'b000) begin n_bad++; $display("FAIL parallel_fail got=%b want=000", fail); end
        set_all(0, 1'b1);
        step();
        $display("txn idle grant=%b fail=%b starve=%b", grant, fail, starve);
        n_cmp++;
        if (grant !== 3'b000) begin n_bad++; $display("FAIL idle_grant got=%b want=000", grant); end
        n_cmp++;
        if (fail !== 3'b000) begin n_bad++; $display("FAIL idle_fail got=%b want=000", fail); end
        n_cmp++;
        if (starve !== 3'b000) begin n_bad++; $display("FAIL idle_starve got=%b want=000", starve); end
    endtask

    task automatic test_enable_hold();
        test_reset();
        set_all(1, 1'b1);
        step();
        n_cmp++;
        if (grant !== 3'b001) begin n_bad++; $display("FAIL hold_first got=%b want=001", grant); end
        enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < NIN; i++) m_dst[i] = $urandom_range(0, NDST - 1);
            step();
            $display("txn hold c=%0d grant=%b fail=%b", c, grant, fail);
            n_cmp++;
            if (grant !== 3'b001) begin n_bad++; $display("FAIL hold_grant c=%0d got=%b want=001", c, grant); end
            n_cmp++;
            if (fail !== 3'b110) begin n_bad++; $display("FAIL hold_fail c=%0d got=%b want=110", c, fail); end
        end
        enable = 1'b1;
        set_all(1, 1'b1);
        step();
        n_cmp++;
        if (grant !== 3'b010) begin n_bad++; $display("FAIL resume_grant1 got=%b want=010", grant); end
        step();
        n_cmp++;
        if (grant !== 3'b100) begin n_bad++; $display("FAIL resume_grant2 got=%b want=100", grant); end
        $display("txn resume grant=%b fail=%b", grant, fail);
    endtask

`ifdef JUDGE_RR_LOCK_EN
    task automatic test_lock_hold();
        test_reset();
        set_all(0, 1'b1);
        m_dst[0] = 1; m_last[0] = 1'b0;
        m_dst[1] = 1;
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) m_last[0] = 1'b1;
            step();
            $display("txn lock c=%0d grant=%b fail=%b starve=%b", c, grant, fail, starve);
            n_cmp++;
            if (grant[0] !== 1'b1) begin n_bad++; $display("FAIL lock_grant0 c=%0d got=%b want=1", c, grant[0]); end
            n_cmp++;
            if (fail[1] !== 1'b1) begin n_bad++; $display("FAIL lock_fail1 c=%0d got=%b want=1", c, fail[1]); end
            n_cmp++;
            if (starve[1] !== (c >= 2)) begin n_bad++; $display("FAIL lock_starve1 c=%0d got=%b want=%b", c, starve[1], c >= 2); end
        end
        step();
        n_cmp++;
        if (grant !== 3'b010) begin n_bad++; $display("FAIL lock_release got=%b want=010", grant); end
        $display("txn lock_release grant=%b fail=%b", grant, fail);
    endtask

    task automatic test_lock_drop();
        test_reset();
        set_all(0, 1'b1);
        m_dst[0] = 1; m_last[0] = 1'b0;
        m_dst[1] = 1;
        step();
        m_dst[0] = 2;
        step();
        $display("txn lock_drop grant=%b fail=%b", grant, fail);
        n_cmp++;
        if (grant !== 3'b011) begin n_bad++; $display("FAIL lock_drop_grant got=%b want=011", grant); end
        n_cmp++;
        if (fail !== 3'b000) begin n_bad++; $display("FAIL lock_drop_fail got=%b want=000", fail); end
    endtask
`endif

    task automatic test_random();
        test_reset();
        for (int t = 0; t < 400; t++) begin
            rst_n  = ($urandom_range(0, 99) >= 2);
            enable = ($urandom_range(0, 99) < 85);
            for (int i = 0; i < NIN; i++) begin
                // Bias toward destination 1 to create sustained contention.
                m_dst[i]  = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(0, NDST - 1);
                m_last[i] = ($urandom_range(0, 3) == 0);
            end
            step();
            $display("txn rnd %0d rst_n=%b en=%b dst=%h last=%b grant=%b fail=%b starve=%b",
                     t, rst_n, enable, dst, last, grant, fail, starve);
            n_cmp++;
            if (grant !== m_grant) begin n_bad++; $display("FAIL rnd_grant t=%0d got=%b want=%b", t, grant, m_grant); end
            n_cmp++;
            if (fail !== m_fail) begin n_bad++; $display("FAIL rnd_fail t=%0d got=%b want=%b", t, fail, m_fail); end
            n_cmp++;
            if (starve !== m_starve) begin n_bad++; $display("FAIL rnd_starve t=%0d got=%b want=%b", t, starve, m_starve); end
        end
        rst_n  = 1'b1;
        enable = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        dst    = '0;
        last   = '0;
        set_all(0, 1'b1);
        model_reset();
        test_reset();
        test_rotation();
        test_parallel();
        test_enable_hold();
`ifdef JUDGE_RR_LOCK_EN
        test_lock_hold();
        test_lock_drop();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
